// File: rtl/dcache_tag_ctrl_if.sv
// ---------------------------------------------------------------------------
// dcache_tag_ctrl_if
// Bundles the requester, response and tag-RAM signals of dcache_tag_ctrl.
//   Requester -> ctrl : flush_req, upd_req/index/tag/valid/dirty,
//                       lkup_req/index/tag
//   Ctrl -> requester : ready, init_busy, resp_valid, resp_hit, resp_dirty,
//                       resp_victim_tag, dbg_state (current FSM state)
//   Ctrl <-> tag RAM  : tag_req, tag_wr_en, tag_addr, tag_wdata (out),
//                       tag_rdata (in)
// Handshake: a request is taken on a rising clock edge where ready=1 and
// its *_req is 1. While ready=0 requests are ignored and must be held by
// the requester. resp_valid is a one-cycle pulse that needs no acknowledge.
// Modports: slave = the controller, master = the requester / RAM side.
// ---------------------------------------------------------------------------
interface dcache_tag_ctrl_if #(
  parameter int NUM_SETS   = 2048,
  parameter int ADDR_WIDTH = $clog2(NUM_SETS),
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int TAG_WIDTH  = 19
) ();
  logic                  flush_req;
  logic                  upd_req;
  logic [ADDR_WIDTH-1:0] upd_index;
  logic [TAG_WIDTH-1:0]  upd_tag;
  logic                  upd_valid;
  logic                  upd_dirty;
  logic                  lkup_req;
  logic [ADDR_WIDTH-1:0] lkup_index;
  logic [TAG_WIDTH-1:0]  lkup_tag;
  logic                  ready;
  logic                  init_busy;
  logic                  resp_valid;
  logic                  resp_hit;
  logic                  resp_dirty;
  logic [TAG_WIDTH-1:0]  resp_victim_tag;
  logic                  tag_req;
  logic [NUM_COL-1:0]    tag_wr_en;
  logic [ADDR_WIDTH-1:0] tag_addr;
  logic [DATA_WIDTH-1:0] tag_wdata;
  logic [DATA_WIDTH-1:0] tag_rdata;
  logic [2:0]            dbg_state;

  modport slave (
    input  flush_req, upd_req, upd_index, upd_tag, upd_valid, upd_dirty,
           lkup_req, lkup_index, lkup_tag, tag_rdata,
    output ready, init_busy, resp_valid, resp_hit, resp_dirty,
           resp_victim_tag, tag_req, tag_wr_en, tag_addr, tag_wdata, dbg_state
  );

  modport master (
    output flush_req, upd_req, upd_index, upd_tag, upd_valid, upd_dirty,
           lkup_req, lkup_index, lkup_tag, tag_rdata,
    input  ready, init_busy, resp_valid, resp_hit, resp_dirty,
           resp_victim_tag, tag_req, tag_wr_en, tag_addr, tag_wdata, dbg_state
  );
endinterface

// File: rtl/dcache_tag_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_tag_ctrl
// Requester-side controller for the data-cache tag RAM. After reset or a
// flush it sweeps every set to invalid, then serves tag updates and tag
// lookups one at a time, so the RAM port never sees a read/write hazard.
// Ports:
//   clk  - clock
//   rst  - asynchronous reset, active-high
//   bus  - dcache_tag_ctrl_if.slave (requests, responses, tag RAM port)
// Entry format: [DATA_WIDTH-1]=valid, [DATA_WIDTH-2]=dirty,
//               [TAG_WIDTH-1:0]=tag, remaining bits 0.
// Every output is a register. The next-cycle output values are computed
// together with the next state, so each output register always shows what
// the current state drives.
// ---------------------------------------------------------------------------
module dcache_tag_ctrl #(
  parameter int NUM_SETS   = 2048,
  parameter int ADDR_WIDTH = $clog2(NUM_SETS),
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int TAG_WIDTH  = 19
) (
  input  logic                 clk,
  input  logic                 rst,
  dcache_tag_ctrl_if.slave     bus
);
  // One extra bit so the counter can reach NUM_SETS: it holds the next set
  // to write, and NUM_SETS means the sweep has issued its last write.
  localparam int CTR_W = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_IDLE = 3'd1,
    ST_RD   = 3'd2,
    ST_CMP  = 3'd3,
    ST_WR   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CTR_W-1:0]      ctr_q, ctr_d;
  logic [TAG_WIDTH-1:0]  ltag_q, ltag_d;

  logic                  ready_q, ready_d;
  logic                  init_busy_q, init_busy_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_hit_q, resp_hit_d;
  logic                  resp_dirty_q, resp_dirty_d;
  logic [TAG_WIDTH-1:0]  resp_vtag_q, resp_vtag_d;
  logic                  tag_req_q, tag_req_d;
  logic [NUM_COL-1:0]    tag_wr_en_q, tag_wr_en_d;
  logic [ADDR_WIDTH-1:0] tag_addr_q, tag_addr_d;
  logic [DATA_WIDTH-1:0] tag_wdata_q, tag_wdata_d;

  logic [DATA_WIDTH-1:0] upd_entry;

  always_comb begin
    upd_entry                 = '0;
    upd_entry[DATA_WIDTH-1]   = bus.upd_valid;
    upd_entry[DATA_WIDTH-2]   = bus.upd_dirty;
    upd_entry[TAG_WIDTH-1:0]  = bus.upd_tag;
  end

  always_comb begin
    state_d      = state_q;
    ctr_d        = ctr_q;
    ltag_d       = ltag_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    resp_dirty_d = resp_dirty_q;
    resp_vtag_d  = resp_vtag_q;
    tag_req_d    = 1'b0;
    tag_wr_en_d  = '0;
    tag_addr_d   = tag_addr_q;
    tag_wdata_d  = tag_wdata_q;

    case (state_q)
      ST_INIT: begin
        if (ctr_q < CTR_W'(NUM_SETS)) begin
          tag_req_d   = 1'b1;
          tag_wr_en_d = '1;
          tag_addr_d  = ctr_q[ADDR_WIDTH-1:0];
          tag_wdata_d = '0;
          ctr_d       = ctr_q + CTR_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.flush_req) begin
          // Restart the sweep; set 0 is written on this same edge.
          state_d     = ST_INIT;
          tag_req_d   = 1'b1;
          tag_wr_en_d = '1;
          tag_addr_d  = '0;
          tag_wdata_d = '0;
          ctr_d       = CTR_W'(1);
        end else if (bus.upd_req) begin
          state_d     = ST_WR;
          tag_req_d   = 1'b1;
          tag_wr_en_d = '1;
          tag_addr_d  = bus.upd_index;
          tag_wdata_d = upd_entry;
        end else if (bus.lkup_req) begin
          state_d    = ST_RD;
          tag_req_d  = 1'b1;
          tag_addr_d = bus.lkup_index;
          ltag_d     = bus.lkup_tag;
        end
      end
      ST_RD: begin
        state_d = ST_CMP;
      end
      ST_CMP: begin
        // tag_rdata carries the entry read during RD.
        state_d      = ST_IDLE;
        resp_valid_d = 1'b1;
        resp_hit_d   = bus.tag_rdata[DATA_WIDTH-1] &&
                       (bus.tag_rdata[TAG_WIDTH-1:0] == ltag_q);
        resp_dirty_d = bus.tag_rdata[DATA_WIDTH-1] && bus.tag_rdata[DATA_WIDTH-2];
        resp_vtag_d  = bus.tag_rdata[TAG_WIDTH-1:0];
      end
      ST_WR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT;
        ctr_d   = '0;
      end
    endcase

    ready_d     = (state_d == ST_IDLE);
    init_busy_d = (state_d == ST_INIT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      ctr_q        <= '0;
      ltag_q       <= '0;
      ready_q      <= 1'b0;
      init_busy_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_dirty_q <= 1'b0;
      resp_vtag_q  <= '0;
      tag_req_q    <= 1'b0;
      tag_wr_en_q  <= '0;
      tag_addr_q   <= '0;
      tag_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      ctr_q        <= ctr_d;
      ltag_q       <= ltag_d;
      ready_q      <= ready_d;
      init_busy_q  <= init_busy_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_dirty_q <= resp_dirty_d;
      resp_vtag_q  <= resp_vtag_d;
      tag_req_q    <= tag_req_d;
      tag_wr_en_q  <= tag_wr_en_d;
      tag_addr_q   <= tag_addr_d;
      tag_wdata_q  <= tag_wdata_d;
    end
  end

  assign bus.ready           = ready_q;
  assign bus.init_busy       = init_busy_q;
  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_hit        = resp_hit_q;
  assign bus.resp_dirty      = resp_dirty_q;
  assign bus.resp_victim_tag = resp_vtag_q;
  assign bus.tag_req         = tag_req_q;
  assign bus.tag_wr_en       = tag_wr_en_q;
  assign bus.tag_addr        = tag_addr_q;
  assign bus.tag_wdata       = tag_wdata_q;
  assign bus.dbg_state       = state_q;
endmodule

// File: tb/tb_dcache_tag_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_tag_ctrl
// Directed bench for dcache_tag_ctrl with a behavioural byte-lane,
// write-first tag RAM (1-cycle read latency). Inputs change and outputs are
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dcache_tag_ctrl;
  localparam int NUM_SETS   = 2048;
  localparam int ADDR_WIDTH = 11;
  localparam int NUM_COL    = 4;
  localparam int COL_WIDTH  = 8;
  localparam int DATA_WIDTH = 32;
  localparam int TAG_WIDTH  = 19;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  dcache_tag_ctrl_if #(
    .NUM_SETS(NUM_SETS), .ADDR_WIDTH(ADDR_WIDTH), .NUM_COL(NUM_COL),
    .COL_WIDTH(COL_WIDTH), .DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)
  ) bus ();

  dcache_tag_ctrl #(
    .NUM_SETS(NUM_SETS), .ADDR_WIDTH(ADDR_WIDTH), .NUM_COL(NUM_COL),
    .COL_WIDTH(COL_WIDTH), .DATA_WIDTH(DATA_WIDTH), .TAG_WIDTH(TAG_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- tag RAM model ----------------
  logic [DATA_WIDTH-1:0] mem [NUM_SETS];

  always @(posedge clk) begin
    if (bus.tag_req) begin
      logic [DATA_WIDTH-1:0] word;
      word = mem[bus.tag_addr];
      for (int l = 0; l < NUM_COL; l++)
        if (bus.tag_wr_en[l]) word[l*COL_WIDTH +: COL_WIDTH] = bus.tag_wdata[l*COL_WIDTH +: COL_WIDTH];
      mem[bus.tag_addr] <= word;
      bus.tag_rdata     <= word;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int budget);
    int cyc = 0;
    while (!bus.ready && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!bus.ready) check("ready_timeout", 64'(bus.ready), 64'd1);
  endtask

  // Called on a falling edge while a sweep is (about to be) in progress.
  task automatic sweep_check(input string name);
    int cnt = 0;
    int bad = 0;
    int busy = 0;
    int cyc = 0;
    while (!bus.ready && cyc < 4000) begin
      if (bus.tag_req) begin
        if (bus.tag_addr !== ADDR_WIDTH'(cnt) || bus.tag_wdata !== '0 ||
            bus.tag_wr_en !== 4'hf) bad++;
        cnt++;
      end
      if (bus.init_busy) busy++;
      @(negedge clk);
      cyc++;
    end
    check({name, "_writes"}, 64'(cnt), 64'd2048);
    check({name, "_bad_writes"}, 64'(bad), 64'd0);
    check({name, "_busy_cycles"}, 64'(busy), 64'd2048);
    check({name, "_ready"}, 64'(bus.ready), 64'd1);
    check({name, "_busy_after"}, 64'(bus.init_busy), 64'd0);
  endtask

  task automatic do_upd(input string name, input logic [ADDR_WIDTH-1:0] idx,
                        input logic [TAG_WIDTH-1:0] tag, input logic v, input logic d,
                        input logic [DATA_WIDTH-1:0] exp_wdata);
    wait_ready(20);
    bus.upd_req = 1'b1; bus.upd_index = idx; bus.upd_tag = tag;
    bus.upd_valid = v;  bus.upd_dirty = d;
    @(posedge clk); @(negedge clk);
    bus.upd_req = 1'b0;
    check({name, "_wr_cycle"}, {61'd0, bus.tag_req, bus.ready, 1'b0}, 64'b100);
    check({name, "_wr_en"}, 64'(bus.tag_wr_en), 64'hf);
    check({name, "_addr"}, 64'(bus.tag_addr), 64'(idx));
    check({name, "_wdata"}, 64'(bus.tag_wdata), 64'(exp_wdata));
    @(negedge clk);
    check({name, "_ready_back"}, 64'(bus.ready), 64'd1);
  endtask

  task automatic do_lkup(input string name, input logic [ADDR_WIDTH-1:0] idx,
                         input logic [TAG_WIDTH-1:0] tag, input logic exp_hit,
                         input logic exp_dirty, input logic [TAG_WIDTH-1:0] exp_vtag);
    int lat;
    wait_ready(20);
    bus.lkup_req = 1'b1; bus.lkup_index = idx; bus.lkup_tag = tag;
    @(posedge clk); @(negedge clk);
    bus.lkup_req = 1'b0;
    check({name, "_rd_cycle"}, {59'd0, bus.tag_req, bus.tag_wr_en}, 64'h10);
    check({name, "_rd_addr"}, 64'(bus.tag_addr), 64'(idx));
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'd3);
    check({name, "_ready"}, 64'(bus.ready), 64'd1);
    check({name, "_hit"}, 64'(bus.resp_hit), 64'(exp_hit));
    check({name, "_dirty"}, 64'(bus.resp_dirty), 64'(exp_dirty));
    check({name, "_victim"}, 64'(bus.resp_victim_tag), 64'(exp_vtag));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.flush_req = 0; bus.upd_req = 0; bus.upd_index = '0; bus.upd_tag = '0;
    bus.upd_valid = 0; bus.upd_dirty = 0; bus.lkup_req = 0; bus.lkup_index = '0;
    bus.lkup_tag = '0;
    bus.tag_rdata = '0;

    repeat (3) @(negedge clk);
    check("rst_tag_req", 64'(bus.tag_req), 64'd0);
    check("rst_ready", 64'(bus.ready), 64'd0);
    check("rst_init_busy", 64'(bus.init_busy), 64'd0);
    check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    check("rst_addr_wdata", {21'd0, bus.tag_addr, bus.tag_wdata}, 64'd0);
    rst = 1'b0;
    sweep_check("init");

    do_lkup("lk_empty", 11'd5, 19'h01234, 1'b0, 1'b0, 19'h0);
    do_upd("upd5", 11'd5, 19'h01234, 1'b1, 1'b1, 32'hC000_1234);
    do_lkup("lk_hit", 11'd5, 19'h01234, 1'b1, 1'b1, 19'h01234);
    do_lkup("lk_miss_dirty", 11'd5, 19'h00042, 1'b0, 1'b1, 19'h01234);
    @(negedge clk);
    check("resp_pulse", 64'(bus.resp_valid), 64'd0);
    check("resp_hold", {62'd0, bus.resp_dirty, bus.resp_hit}, 64'b10);

    // Invalid entry with dirty set: no hit, no dirty, stored tag still reported.
    do_upd("upd12", 11'd12, 19'h00055, 1'b0, 1'b1, 32'h4000_0055);
    do_lkup("lk_invalid", 11'd12, 19'h00055, 1'b0, 1'b0, 19'h00055);

    // Update and lookup in the same ready cycle: the write goes first.
    wait_ready(20);
    bus.upd_req = 1'b1; bus.upd_index = 11'd9; bus.upd_tag = 19'h7abcd;
    bus.upd_valid = 1'b1; bus.upd_dirty = 1'b0;
    bus.lkup_req = 1'b1; bus.lkup_index = 11'd9; bus.lkup_tag = 19'h7abcd;
    @(posedge clk); @(negedge clk);
    bus.upd_req = 1'b0;
    check("both_wr_first", {59'd0, bus.tag_req, bus.tag_wr_en}, 64'h1f);
    check("both_wdata", 64'(bus.tag_wdata), 64'h8007_abcd);
    do_lkup("lk_after_upd", 11'd9, 19'h7abcd, 1'b1, 1'b0, 19'h7abcd);

    // Flush clears every set.
    wait_ready(20);
    bus.flush_req = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.flush_req = 1'b0;
    check("flush_busy", 64'(bus.init_busy), 64'd1);
    sweep_check("flush");
    do_lkup("lk_flushed", 11'd5, 19'h01234, 1'b0, 1'b0, 19'h0);

    // Reset in the middle of a sweep restarts it from set 0.
    do_upd("upd7", 11'd7, 19'h00777, 1'b1, 1'b1, 32'hC000_0777);
    wait_ready(20);
    bus.flush_req = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.flush_req = 1'b0;
    cyc = 0;
    while (!(bus.tag_req && bus.tag_addr == 11'd1000) && cyc < 1500) begin
      @(negedge clk);
      cyc++;
    end
    check("reach_addr_1000", 64'(bus.tag_addr), 64'd1000);
    rst = 1'b1;
    #1;
    check("midrst_outputs", {59'd0, bus.tag_req, bus.init_busy, bus.ready,
                             bus.resp_valid, bus.resp_hit}, 64'd0);
    check("midrst_addr", 64'(bus.tag_addr), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    sweep_check("rst_sweep");
    do_lkup("lk_after_rst", 11'd7, 19'h00777, 1'b0, 1'b0, 19'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
